// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch controller: owns the PC, holds the memory address for RD_WAIT
// cycles, captures the returned word and presents it to decode over valid/ready.
module instr_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          RD_WAIT  = 2,
    parameter int          CNT_W    = 4
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        Enable,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic [63:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    output logic        Busy,
    output logic        Fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT - 1);

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [63:0]        ipc_q, ipc_d;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        if (state_q != S_FAULT) begin
            if (Redirect) begin
                // A redirect also swallows any handshake or capture happening this cycle.
                cnt_d = '0;
                if (RedirectPC[1:0] != 2'b00) begin
                    state_d = S_FAULT;
                end else begin
                    pc_d    = RedirectPC;
                    state_d = Enable ? S_FETCH : S_IDLE;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (Enable) begin
                            state_d = S_FETCH;
                            cnt_d   = '0;
                        end
                    end
                    S_FETCH: begin
                        if (cnt_q == CNT_LAST) begin
                            instr_d = IMemData;
                            ipc_d   = pc_q;
                            pc_d    = pc_q + 64'd4;
                            cnt_d   = '0;
                            state_d = S_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (InstrReady) begin
                            cnt_d   = '0;
                            state_d = Enable ? S_FETCH : S_IDLE;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    assign IMemAddr   = pc_q;
    assign Instr      = instr_q;
    assign InstrPC    = ipc_q;
    assign InstrValid = (state_q == S_HOLD);
    assign Busy       = (state_q == S_FETCH) || (state_q == S_HOLD);
    assign Fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural fetch model.
module tb_instr_fetch_sequencer;

    localparam int RW = 2;

    logic        CLK;
    logic        Reset_L;
    logic        Enable;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic [63:0] IMemAddr;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        Busy;
    logic        Fault;

    instr_fetch_sequencer #(
        .RESET_PC(64'h0),
        .RD_WAIT (RW),
        .CNT_W   (4)
    ) dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .Enable    (Enable),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .IMemAddr  (IMemAddr),
        .IMemData  (IMemData),
        .InstrValid(InstrValid),
        .InstrReady(InstrReady),
        .Instr     (Instr),
        .InstrPC   (InstrPC),
        .Busy      (Busy),
        .Fault     (Fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a[63:6] == 58'h0) begin
            case (a[5:2])
                4'd0: return 32'hF84003E9;
                4'd1: return 32'hF84083EA;
                4'd2: return 32'hF84103EB;
                4'd3: return 32'hF84183EC;
                4'd4: return 32'h8B020020;
                4'd5: return 32'hCB030041;
                4'd6: return 32'hD503201F;
                4'd7: return 32'hB40000AC;
                4'd8: return 32'h17FFFFF8;
                default: return 32'h10000000 | {26'h0, a[5:0]};
            endcase
        end
        return a[31:0] ^ a[63:32] ^ 32'h5A5AC3C3;
    endfunction

    // Memory only returns the real word once the address has been stable long enough.
    int          stable;
    logic [63:0] last_addr;
    initial begin
        stable    = 0;
        last_addr = '0;
    end
    always @(negedge CLK) begin
        if (IMemAddr != last_addr) stable <= 0;
        else if (stable < 15)      stable <= stable + 1;
        last_addr <= IMemAddr;
    end
    assign IMemData = (stable >= RW - 1) ? mem_word(IMemAddr) : (32'hBAD00000 ^ IMemAddr[31:0]);

    // Behavioural model
    bit          m_valid, m_fetch, m_fault;
    int          m_wait;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;

    task automatic model_reset();
        m_valid = 0; m_fetch = 0; m_fault = 0; m_wait = 0;
        m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
    endtask

    task automatic model_step(input bit en, input bit rd, input logic [63:0] rpc, input bit rdy);
        if (!Reset_L) begin
            model_reset();
        end else if (m_fault) begin
            m_valid = 0;
        end else if (rd) begin
            m_valid = 0;
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1;
                m_fetch = 0;
            end else begin
                m_pc    = rpc;
                m_fetch = en;
                m_wait  = RW;
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 0;
                m_fetch = en;
                m_wait  = RW;
            end
        end else if (m_fetch) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_instr = mem_word(m_pc);
                m_ipc   = m_pc;
                m_pc    = m_pc + 64'd4;
                m_valid = 1;
                m_fetch = 0;
            end
        end else if (en) begin
            m_fetch = 1;
            m_wait  = RW;
        end
    endtask

    int checks, errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, 64'(InstrValid), 64'(m_valid));
        chk({tag, ".instr"}, 64'(Instr), 64'(m_instr));
        chk({tag, ".ipc"},   InstrPC, m_ipc);
        chk({tag, ".addr"},  IMemAddr, m_pc);
        chk({tag, ".busy"},  64'(Busy), 64'(m_fetch | m_valid));
        chk({tag, ".fault"}, 64'(Fault), 64'(m_fault));
    endtask

    task automatic step(input bit en, input bit rd, input logic [63:0] rpc, input bit rdy);
        Enable = en; Redirect = rd; RedirectPC = rpc; InstrReady = rdy;
        @(posedge CLK);
        model_step(en, rd, rpc, rdy);
        @(negedge CLK);
    endtask

    typedef struct {
        bit          en;
        bit          rd;
        logic [63:0] rpc;
        bit          rdy;
        bit          valid;
        logic [31:0] instr;
        logic [63:0] ipc;
        logic [63:0] addr;
        bit          busy;
        bit          fault;
    } vec_t;

    function automatic vec_t mk(input bit en, input bit rd, input logic [63:0] rpc, input bit rdy,
                                input bit valid, input logic [31:0] instr, input logic [63:0] ipc,
                                input logic [63:0] addr, input bit busy, input bit fault);
        vec_t v;
        v.en = en; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.valid = valid; v.instr = instr; v.ipc = ipc; v.addr = addr; v.busy = busy; v.fault = fault;
        return v;
    endfunction

    vec_t tbl [21];

    task automatic pulse_reset();
        Reset_L = 1'b0;
        #1;
        model_reset();
        chk("rst.valid", 64'(InstrValid), 64'h0);
        chk("rst.addr",  IMemAddr, 64'h0);
        chk("rst.busy",  64'(Busy), 64'h0);
        chk("rst.fault", 64'(Fault), 64'h0);
        chk("rst.instr", 64'(Instr), 64'h0);
        chk("rst.ipc",   InstrPC, 64'h0);
        @(posedge CLK);
        @(negedge CLK);
        Reset_L = 1'b1;
    endtask

    initial begin
        logic [63:0] rpc;
        int          r;
        checks = 0; errors = 0;
        Enable = 0; Redirect = 0; RedirectPC = '0; InstrReady = 0;
        model_reset();

        tbl[0]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h0,        64'h0,  64'h0,  1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h0,        64'h0,  64'h0,  1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 32'hF84003E9, 64'h0,  64'h4,  1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'hF84003E9, 64'h0,  64'h4,  1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'hF84003E9, 64'h0,  64'h4,  1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'hF84083EA, 64'h4,  64'h8,  1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'hF84083EA, 64'h4,  64'h8,  1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 32'hF84083EA, 64'h4,  64'h8,  1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 32'hF84083EA, 64'h4,  64'h8,  1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 64'h1C, 1'b0, 1'b0, 32'hF84083EA, 64'h4,  64'h1C, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 32'hF84083EA, 64'h4,  64'h1C, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 32'hF84083EA, 64'h4,  64'h1C, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'hB40000AC, 64'h1C, 64'h20, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 64'hC,  1'b1, 1'b0, 32'hB40000AC, 64'h1C, 64'hC,  1'b0, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 32'hB40000AC, 64'h1C, 64'hC,  1'b1, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 64'h10, 1'b0, 1'b0, 32'hB40000AC, 64'h1C, 64'h10, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 32'hB40000AC, 64'h1C, 64'h10, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'h8B020020, 64'h10, 64'h14, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 64'h22, 1'b0, 1'b0, 32'h8B020020, 64'h10, 64'h14, 1'b0, 1'b1);
        tbl[19] = mk(1'b1, 1'b1, 64'h40, 1'b1, 1'b0, 32'h8B020020, 64'h10, 64'h14, 1'b0, 1'b1);
        tbl[20] = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h8B020020, 64'h10, 64'h14, 1'b0, 1'b1);

        // Power-on reset
        Reset_L = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("por.valid", 64'(InstrValid), 64'h0);
        chk("por.addr",  IMemAddr, 64'h0);
        chk("por.busy",  64'(Busy), 64'h0);
        chk("por.fault", 64'(Fault), 64'h0);
        chk("por.instr", 64'(Instr), 64'h0);
        chk("por.ipc",   InstrPC, 64'h0);
        Reset_L = 1'b1;

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].en, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("vec%0d.valid", i), 64'(InstrValid), 64'(tbl[i].valid));
            chk($sformatf("vec%0d.instr", i), 64'(Instr), 64'(tbl[i].instr));
            chk($sformatf("vec%0d.ipc", i),   InstrPC, tbl[i].ipc);
            chk($sformatf("vec%0d.addr", i),  IMemAddr, tbl[i].addr);
            chk($sformatf("vec%0d.busy", i),  64'(Busy), 64'(tbl[i].busy));
            chk($sformatf("vec%0d.fault", i), 64'(Fault), 64'(tbl[i].fault));
        end

        // Leave FAULT through reset
        pulse_reset();

        // Decode stall: word and address held while not ready
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 64'h0, 1'b0);
            chk("stall.valid", 64'(InstrValid), 64'h1);
            chk("stall.instr", 64'(Instr), 64'hF84003E9);
            chk("stall.ipc",   InstrPC, 64'h0);
            chk("stall.addr",  IMemAddr, 64'h4);
        end
        step(1'b1, 1'b0, 64'h0, 1'b1);
        chk("release.valid", 64'(InstrValid), 64'h0);
        chk("release.busy",  64'(Busy), 64'h1);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        chk("next.valid", 64'(InstrValid), 64'h1);
        chk("next.instr", 64'(Instr), 64'hF84083EA);
        chk("next.ipc",   InstrPC, 64'h4);

        // Asynchronous reset while holding a word, then restart from 0
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
        chk("restart.valid", 64'(InstrValid), 64'h1);
        chk("restart.instr", 64'(Instr), 64'hF84003E9);
        chk("restart.ipc",   InstrPC, 64'h0);

        // PC wrap at the top of the address space
        step(1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("wrap.valid", 64'(InstrValid), 64'h1);
        chk("wrap.ipc",   InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap.addr",  IMemAddr, 64'h0);
        chk("wrap.instr", 64'(Instr), 64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
        step(1'b0, 1'b0, 64'h0, 1'b1);
        cmp_model("wrap.done");

        // Randomized run against the model
        pulse_reset();
        for (int i = 0; i < 2000; i++) begin
            Reset_L = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            r = $urandom_range(0, 9);
            if (r < 6)      rpc = {58'h0, 4'($urandom_range(0, 15)), 2'b00};
            else if (r < 8) rpc = {$urandom, $urandom} & ~64'h3;
            else            rpc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, 2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 1) == 1);
            cmp_model($sformatf("rnd%0d", i));
        end
        Reset_L = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
